// File: rtl/pipeline_window_sequencer.sv
// Sequencer for the denoise/merge sliding window: drives stage_en, tracks the centre pixel and drains the window at end of frame.
// Optional frame counter enabled by defining PIPE_SEQ_FRAME_COUNT_EN.
module pipeline_window_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int RADIUS = 5,
    parameter int CW     = 13,
    parameter int PW     = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          stage_en,
    output logic          out_valid,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_border,
    output logic          frame_done,
    output logic          busy,
    output logic          err_overlap,
    output logic [15:0]   frame_count
);

    localparam int D = RADIUS * WIDTH + RADIUS;

    localparam logic [PW-1:0] D_P      = PW'(D);
    localparam logic [PW-1:0] FIRST_P  = PW'(D + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(WIDTH * HEIGHT - 1);

    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(HEIGHT - 1);
    localparam logic [CW-1:0] RAD_C   = CW'(RADIUS);
    localparam logic [CW-1:0] COL_HI  = CW'(WIDTH - 1 - RADIUS);
    localparam logic [CW-1:0] ROW_HI  = CW'(HEIGHT - 1 - RADIUS);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] p;
    logic [PW-1:0] idx;
    logic [PW-1:0] dc;

    logic          drain_active;
    logic          overlap;
    logic [PW-1:0] p_next;
    logic          centre_ok;
    logic [CW-1:0] nrow;
    logic [CW-1:0] ncol;

    function automatic logic is_border(input logic [CW-1:0] row, input logic [CW-1:0] col);
        return (row < RAD_C) || (row > ROW_HI) || (col < RAD_C) || (col > COL_HI);
    endfunction

    assign drain_active = (state == DRAIN) && (dc < D_P);
    assign overlap      = (state == DRAIN) && in_valid;
    assign p_next       = p + 1'b1;
    assign centre_ok    = (p_next >= FIRST_P);
    assign busy         = (state != IDLE);

    // A new pixel arriving during drain is pushed too, since it starts the next frame.
    always_comb begin
        stage_en = in_valid;
        if (state == DRAIN) begin
            stage_en = drain_active || in_valid;
        end
    end

    // First valid centre of a frame is always (0,0); later ones advance in raster order.
    always_comb begin
        nrow = out_row;
        ncol = out_col;
        if (p_next == FIRST_P) begin
            nrow = '0;
            ncol = '0;
        end else if (out_col >= COL_MAX) begin
            ncol = '0;
            nrow = (out_row >= ROW_MAX) ? '0 : out_row + 1'b1;
        end else begin
            ncol = out_col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            p           <= '0;
            idx         <= '0;
            dc          <= '0;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_col     <= '0;
            out_border  <= 1'b0;
            frame_done  <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            if (overlap) begin
                // Abandon the drain; this pixel becomes index 0 of a fresh frame.
                err_overlap <= 1'b1;
                state       <= PRIME;
                p           <= PW'(1);
                idx         <= PW'(1);
                dc          <= '0;
                out_row     <= '0;
                out_col     <= '0;
            end else begin
                if (stage_en) begin
                    p <= p_next;
                    if (centre_ok) begin
                        out_valid  <= 1'b1;
                        out_row    <= nrow;
                        out_col    <= ncol;
                        out_border <= is_border(nrow, ncol);
                    end
                end
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            state <= PRIME;
                            idx   <= PW'(1);
                        end
                    end
                    PRIME, RUN: begin
                        if (in_valid) begin
                            idx <= idx + 1'b1;
                            if (idx >= LAST_IDX) begin
                                state <= DRAIN;
                                dc    <= '0;
                            end else if (state == PRIME && centre_ok) begin
                                state <= RUN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_active) begin
                            dc <= dc + 1'b1;
                        end else begin
                            state      <= IDLE;
                            p          <= '0;
                            idx        <= '0;
                            dc         <= '0;
                            frame_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PIPE_SEQ_FRAME_COUNT_EN
    logic [15:0] fcnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fcnt <= '0;
        end else if (frame_done) begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign frame_count = fcnt;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_window_sequencer.sv
// Directed bench for pipeline_window_sequencer at WIDTH=8, HEIGHT=6, RADIUS=1 (D=9).
module tb_pipeline_window_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int R  = 1;
    localparam int CW = 13;
    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          stage_en;
    logic          out_valid;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_border;
    logic          frame_done;
    logic          busy;
    logic          err_overlap;
    logic [15:0]   frame_count;

    pipeline_window_sequencer #(
        .WIDTH(W), .HEIGHT(H), .RADIUS(R), .CW(CW), .PW(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stage_en(stage_en),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .out_border(out_border), .frame_done(frame_done), .busy(busy),
        .err_overlap(err_overlap), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   tick_no = 0;
    int   secnt, vcnt, drain_cnt, fd_cnt, first_se, drain_first, drain_last;
    int   erow, ecol, last_row, last_col;
    logic fd_busy;
    logic bmap [H][W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        secnt = 0; vcnt = 0; drain_cnt = 0; fd_cnt = 0; first_se = -1;
        drain_first = -1; drain_last = -1; erow = 0; ecol = 0;
        last_row = -1; last_col = -1; fd_busy = 1'bx;
    endtask

    task automatic tick(input logic v);
        in_valid = v;
        #1;
        if (stage_en === 1'b1) begin
            secnt++;
            if (!v) begin
                drain_cnt++;
                if (drain_first < 0) drain_first = tick_no;
                drain_last = tick_no;
            end
        end
        @(posedge clk);
        #1;
        tick_no++;
        if (out_valid === 1'b1) begin
            if (vcnt == 0) first_se = secnt;
            chk("raster_row", 32'(out_row), erow);
            chk("raster_col", 32'(out_col), ecol);
            if (erow < H && ecol < W) bmap[erow][ecol] = out_border;
            last_row = int'(out_row);
            last_col = int'(out_col);
            vcnt++;
            if (ecol == W - 1) begin
                ecol = 0;
                erow = (erow == H - 1) ? 0 : erow + 1;
            end else begin
                ecol++;
            end
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_busy = busy;
        end
    endtask

    task automatic run_to_done();
        for (int i = 0; i < 60 && fd_cnt == 0; i++) tick(1'b0);
        chk("frame_done_seen", fd_cnt, 1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_valid_count"}, vcnt, 48);
        chk({tag, "_drain_pulses"}, drain_cnt, 9);
        chk({tag, "_drain_back_to_back"}, drain_last - drain_first, 8);
        chk({tag, "_last_row"}, last_row, 5);
        chk({tag, "_last_col"}, last_col, 7);
        chk({tag, "_busy_at_done"}, 32'(fd_busy), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        clear_stats();

        // Power-on reset
        tick(1'b0); tick(1'b0); tick(1'b0);
        reset_n = 1'b1;
        tick(1'b0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_overlap), 0);
        chk("rst_fcount", 32'(frame_count), 0);
        chk("rst_row", 32'(out_row), 0);
        chk("rst_col", 32'(out_col), 0);

        // Frame A: continuous input
        clear_stats();
        for (int i = 0; i < 48; i++) tick(1'b1);
        chk("A_busy_after_input", 32'(busy), 1);
        run_to_done();
        chk("A_first_valid_after_se", first_se, 10);
        chk("A_border_0_0", 32'(bmap[0][0]), 1);
        chk("A_border_1_1", 32'(bmap[1][1]), 0);
        chk("A_border_1_6", 32'(bmap[1][6]), 0);
        chk("A_border_1_7", 32'(bmap[1][7]), 1);
        chk("A_border_5_7", 32'(bmap[5][7]), 1);
        chk("A_total_stage_en", secnt, 57);
        check_frame("A");
        tick(1'b0);
        chk("A_frame_done_one_cycle", 32'(frame_done), 0);
        chk("A_no_overlap", 32'(err_overlap), 0);

        // Frames B and C: gapped input, C starts in the frame_done cycle of B
        reset_n = 1'b0;
        tick(1'b0);
        reset_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 48; i++) begin
            if (i % 5 == 2) tick(1'b0);
            if (i % 7 == 3) begin
                tick(1'b0);
                tick(1'b0);
            end
            tick(1'b1);
        end
        run_to_done();
        check_frame("B");
        clear_stats();
        for (int i = 0; i < 48; i++) begin
            tick(1'b1);
            if (i % 4 == 1) tick(1'b0);
        end
        run_to_done();
        check_frame("C");
        chk("C_err_clear", 32'(err_overlap), 0);
        tick(1'b0);
`ifdef PIPE_SEQ_FRAME_COUNT_EN
        chk("BC_frame_count", 32'(frame_count), 2);
`else
        chk("BC_frame_count", 32'(frame_count), 0);
`endif

        // Frame D: overlap on the 4th drain cycle
        clear_stats();
        for (int i = 0; i < 48; i++) tick(1'b1);
        tick(1'b0); tick(1'b0); tick(1'b0);
        chk("D_err_before", 32'(err_overlap), 0);
        clear_stats();
        tick(1'b1);
        chk("D_err_set", 32'(err_overlap), 1);
        chk("D_busy_after_overlap", 32'(busy), 1);
        for (int i = 1; i < 48; i++) tick(1'b1);
        chk("D_no_done_for_abandoned", fd_cnt, 0);
        chk("D_first_valid_after_se", first_se, 10);
        run_to_done();
        chk("D_valid_count", vcnt, 48);
        chk("D_last_row", last_row, 5);
        chk("D_last_col", last_col, 7);
        chk("D_err_sticky", 32'(err_overlap), 1);

        // Reset in the middle of a drain
        clear_stats();
        for (int i = 0; i < 48; i++) tick(1'b1);
        tick(1'b0); tick(1'b0);
        chk("E_busy_in_drain", 32'(busy), 1);
        reset_n = 1'b0;
        tick(1'b0); tick(1'b0); tick(1'b0);
        reset_n = 1'b1;
        tick(1'b0);
        chk("E_out_valid", 32'(out_valid), 0);
        chk("E_frame_done", 32'(frame_done), 0);
        chk("E_busy", 32'(busy), 0);
        chk("E_err", 32'(err_overlap), 0);
        chk("E_fcount", 32'(frame_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
